// File: rtl/instr_memory_loader.sv
// instr_memory_loader: byte-stream program loader with registered little-endian instruction fetch.
module instr_memory_loader #(
  parameter int DATAWIDTH  = 8,
  parameter int ADDWIDTH   = 7,
  parameter int INSTRBYTES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_start,
  input  logic                            load_valid,
  input  logic [DATAWIDTH-1:0]            load_data,
  input  logic                            load_last,
  output logic                            load_ready,
  output logic [ADDWIDTH:0]               load_count,
  input  logic                            fetch_req,
  input  logic [ADDWIDTH-1:0]             fetch_addr,
  output logic                            fetch_valid,
  output logic [DATAWIDTH*INSTRBYTES-1:0] instruction,
  output logic                            misaligned,
  output logic                            fetch_err,
  output logic                            busy
);
  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;
  localparam logic [ADDWIDTH-1:0] AMASK = ADDWIDTH'(INSTRBYTES - 1);
  state_t state_q, state_d;
  logic [ADDWIDTH-1:0] ptr_q, ptr_d;
  logic [ADDWIDTH:0] count_q, count_d;
  logic fetch_valid_q, fetch_valid_d, fetch_err_q, fetch_err_d, misaligned_q, misaligned_d;
  logic [DATAWIDTH*INSTRBYTES-1:0] instr_q, instr_d, rd_word;
  logic [DATAWIDTH-1:0] mem [2**ADDWIDTH];
  logic accept, full, start, fetch_ok;
  assign accept   = state_q == LOAD && load_valid;
  assign full     = &ptr_q;
  assign start    = state_q != LOAD && load_start;
  assign fetch_ok = state_q == READY && fetch_req && !load_start;
  genvar k;
  for (k = 0; k < INSTRBYTES; k++) begin : g_rd
    assign rd_word[k*DATAWIDTH +: DATAWIDTH] = mem[fetch_addr + ADDWIDTH'(k)];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = start ? LOAD : (accept && (load_last || full)) ? READY : state_q;
  always_comb begin
    ptr_d        = start ? '0 : accept ? ptr_q + 1'b1 : ptr_q;
    count_d      = start ? '0 : accept ? count_q + 1'b1 : count_q;
    fetch_valid_d = fetch_ok;
    fetch_err_d  = fetch_req && !fetch_ok;
    misaligned_d = fetch_ok ? |(fetch_addr & AMASK) : misaligned_q;
    instr_d      = fetch_ok ? rd_word : instr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr_q         <= '0;
      count_q       <= '0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      misaligned_q  <= 1'b0;
      instr_q       <= '0;
    end else begin
      ptr_q         <= ptr_d;
      count_q       <= count_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      misaligned_q  <= misaligned_d;
      instr_q       <= instr_d;
    end
  // Memory contents survive reset so an aborted load keeps what it wrote.
  always_ff @(posedge clk)
    if (accept) mem[ptr_q] <= load_data;
  assign load_ready  = state_q == LOAD;
  assign busy        = state_q == LOAD;
  assign load_count  = count_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_err   = fetch_err_q;
  assign misaligned  = misaligned_q;
  assign instruction = instr_q;
endmodule

// File: tb/tb_instr_memory_loader.sv
// tb_instr_memory_loader: scoreboard bench with a behavioural loader/memory model.
module tb_instr_memory_loader;
  localparam int DEPTH = 128;
  localparam int IB = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic load_start = 0, load_valid = 0, load_last = 0, fetch_req = 0;
  logic [7:0] load_data = 0;
  logic [6:0] fetch_addr = 0;
  logic load_ready, fetch_valid, misaligned, fetch_err, busy;
  logic [7:0] load_count;
  logic [31:0] instruction;
  instr_memory_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .load_count(load_count), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .instruction(instruction), .misaligned(misaligned),
    .fetch_err(fetch_err), .busy(busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {bit err; logic [31:0] w; bit mis; int due;} exp_t;
  exp_t q[$];
  int n_vec = 0, n_bad = 0;
  logic [7:0] mm [DEPTH];
  int mst = 0, mptr = 0, mcnt = 0;
  logic [31:0] mins = 0;
  bit mmis = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [31:0] word(input int a);
    logic [31:0] w;
    for (int k = 0; k < IB; k++) w[k*8 +: 8] = mm[(a + k) % DEPTH];
    return w;
  endfunction
  task automatic step(input bit ls, input bit lv, input logic [7:0] ld, input bit ll,
                      input bit fr, input int fa);
    exp_t e;
    load_start = ls; load_valid = lv; load_data = ld; load_last = ll;
    fetch_req = fr; fetch_addr = 7'(fa);
    if (fr) begin
      if (mst == 2 && !ls) begin
        mins = word(fa);
        mmis = (fa % IB) != 0;
        e = '{1'b0, mins, mmis, cyc + 1};
      end else e = '{1'b1, mins, mmis, cyc + 1};
      q.push_back(e);
    end
    if (mst != 1 && ls) begin
      mst = 1; mptr = 0; mcnt = 0;
    end else if (mst == 1 && lv) begin
      mm[mptr] = ld;
      mcnt++;
      if (ll || mptr == DEPTH - 1) mst = 2;
      mptr++;
    end
    @(posedge clk);
    #1;
    load_start = 0; load_valid = 0; load_last = 0; fetch_req = 0;
  endtask
  always @(negedge clk) if (!rst) begin
    exp_t e;
    bit due;
    due = q.size() > 0 && q[0].due == cyc;
    if (fetch_valid || fetch_err || due) begin
      if (!due) chk("unexpected_pulse", {fetch_valid, fetch_err}, 2'b00);
      else begin
        e = q.pop_front();
        chk("pulse_kind", {fetch_valid, fetch_err}, e.err ? 2'b01 : 2'b10);
        chk("instr", instruction, e.w);
        if (!e.err) chk("misaligned", misaligned, e.mis);
      end
    end
  end
  task automatic chk_reset(input string nm);
    chk({nm, "_busy"}, {load_ready, busy, fetch_valid, fetch_err, misaligned}, 5'b0);
    chk({nm, "_count"}, load_count, 0);
    chk({nm, "_instr"}, instruction, 0);
  endtask
  initial begin
    #12;
    chk_reset("reset");
    rst = 0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 1, 5);
    chk("idle_err", {fetch_err, fetch_valid, instruction}, {2'b10, 32'h0});
    step(1, 0, 0, 0, 0, 0);
    chk("load_busy", {busy, load_ready}, 2'b11);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i), 0, 0, 0);
    chk("full_count", load_count, 128);
    chk("full_ready", {busy, load_ready}, 2'b00);
    step(0, 0, 0, 0, 1, 126);
    chk("wrap_word", instruction, 32'h01007F7E);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 8'h11, 0, 0, 0);
    step(0, 1, 8'h22, 0, 0, 0);
    step(0, 1, 8'h33, 0, 0, 0);
    step(0, 1, 8'h44, 1, 0, 0);
    chk("short_count", load_count, 4);
    chk("short_busy", busy, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("aligned", {fetch_valid, misaligned, instruction}, {2'b10, 32'h44332211});
    step(0, 0, 0, 0, 1, 1);
    chk("unaligned", {fetch_valid, misaligned, instruction[23:0]}, {2'b11, 24'h443322});
    step(0, 0, 0, 0, 1, 127);
    step(0, 0, 0, 0, 1, 3);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 8'hA1, 0, 0, 0);
    step(0, 1, 8'hA2, 0, 1, 2);
    chk("midload_err", {fetch_err, fetch_valid, instruction}, {2'b10, mins});
    rst = 1;
    #1;
    chk_reset("async_reset");
    q.delete();
    mst = 0; mptr = 0; mcnt = 0; mins = 0; mmis = 0;
    rst = 0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 8'h5A, 1, 0, 0);
    chk("reload_count", load_count, 1);
    chk("reload_busy", busy, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("load_wins", {busy, fetch_err, fetch_valid}, 3'b110);
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)));
      chk("rand_count", load_count, mcnt);
      chk("rand_busy", busy, mst == 1);
    end
    repeat (2) @(posedge clk);
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
